// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit (0), WIDTH data bits LSB-first, stop bit (1),
// with each bit held for CLKS_PER_BIT clocks. The line idles high and every output is registered.
module piso_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [TW-1:0]    tick_cnt, tick_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic             serial_next, ready_next, done_next;
  logic             bit_end;

  assign bit_end = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b1;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      tick_cnt   <= tick_next;
      bit_cnt    <= bit_next;
      serial_out <= serial_next;
      ready      <= ready_next;
      done       <= done_next;
    end
  end

  // The tick counter paces every non-idle state; the register only shifts between data bits.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = START;
          shift_next = data_in;
          tick_next  = '0;
          bit_next   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tick_next  = '0;
        end else begin
          tick_next = tick_cnt + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + BW'(1);
            shift_next = shift_reg >> 1;
          end
        end else begin
          tick_next = tick_cnt + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          tick_next  = '0;
        end else begin
          tick_next = tick_cnt + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the registers show it from the entering edge.
  always_comb begin
    serial_next = 1'b1;
    ready_next  = (state_next == IDLE);
    done_next   = (state == STOP) && (state_next == IDLE);
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      default: serial_next = 1'b1;
    endcase
  end

endmodule
